mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0, meaning the requester favoured on the first contested grant after reset (0 = fetch, 1 = data).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have fetch-port inputs: i_req (1, access request) and i_addr (32, byte address).
REQ-005 SHALL have fetch-port outputs: i_gnt (1, request accepted), i_rvalid (1, response valid), i_rdata (32, fetched word) and i_err (1, misaligned).
REQ-006 SHALL have data-port inputs: d_req (1), d_we (1, 1 = store), d_size (2: 00 byte, 01 half, 10 word, 11 illegal), d_unsigned (1, zero-extend loads), d_addr (32) and d_wdata (32, store data, unshifted).
REQ-007 SHALL have data-port outputs: d_gnt (1), d_rvalid (1), d_rdata (32) and d_err (1, misaligned or illegal size).
REQ-008 SHALL have memory-side outputs mem_we (1), mem_a (32), mem_wd (32) and mem_wm (4, byte-lane mask), plus input mem_rd (32, combinational read of word mem_a[31:2]).

Function
REQ-009 SHALL implement states IDLE, ACCESS and RESP.
REQ-010 SHALL accept a request only in IDLE or RESP; x_gnt is combinational, high for exactly one cycle, for at most one port per cycle.
REQ-011 Arbitration SHALL work as follows: single requester is granted; if both request, the port not granted last wins (round-robin); the last-grant register is reset so FIRST_PRIO wins first.
REQ-012 On the grant edge, SHALL latch address, we, size, unsigned, wdata and port id, then go to ACCESS; with no grant, RESP goes to IDLE and IDLE stays IDLE.
REQ-013 ACCESS SHALL drive mem_a = latched address and mem_wd = latched wdata, register the extended read data and error, then go to RESP.
REQ-014 RESP SHALL assert x_rvalid on the served port only, for one cycle, with x_rdata and x_err; latency from grant cycle to rvalid is 2 cycles; sustained throughput is one access per 2 cycles.
REQ-015 Requesters SHALL hold req and request fields until gnt; changes before gnt are allowed and the values sampled in the grant cycle are used.
REQ-016 Alignment SHALL be: fetch and word require a[1:0]=00, half requires a[0]=0, byte has no constraint; d_size=11 is an error.
REQ-017 mem_we SHALL be high only in ACCESS, for an aligned, legal data store.
REQ-018 mem_wm SHALL be: word 1111; half a[1]=0 0011, a[1]=1 1100; byte a[1:0]=00 0001, 01 0010, 10 0100, 11 1000; 0000 whenever mem_we=0.
REQ-019 Load data SHALL use the lane selected by a[1:0] (byte) or a[1] (half) of mem_rd, right-justified, sign-extended unless d_unsigned=1; word and fetch return mem_rd unchanged.
REQ-020 On error, SHALL give no memory write, rdata=0 and err=1 in RESP.
REQ-021 A request arriving in RESP SHALL be granted in that same cycle while rvalid for the previous access is asserted.

Reset
REQ-022 While reset_n=0, SHALL hold state IDLE, last-grant per FIRST_PRIO, all gnt/rvalid/err/mem_we = 0, rdata = 0, mem_a/mem_wd/latched fields = 0 and mem_wm = 0000.
REQ-023 Reset asserted in ACCESS SHALL drop mem_we immediately (asynchronously) with no partial write and no rvalid afterwards.
REQ-024 After reset_n rises, the first grant SHALL be possible in the first clock edge's cycle.

Verification
REQ-025 Fetch i_addr=0x10 with mem word 0x00A00093 -> i_gnt in cycle N, i_rvalid=1 with i_rdata=0x00A00093 and i_err=0 in cycle N+2.
REQ-026 Both req held, FIRST_PRIO=0 -> grants alternate I, D, I, D on successive accept cycles, with no cycle granting both.
REQ-027 Store byte d_addr=0x23, d_wdata=0x000000AB -> in ACCESS mem_we=1, mem_wm=1000, mem_a=0x23; reading word 0x20 afterwards gives 0xAB in [31:24].
REQ-028 Load half at 0x22 with mem word 0x8001_0000: signed -> d_rdata=0xFFFF8001; unsigned -> 0x00008001.
REQ-029 Store word at d_addr=0x06 -> mem_we stays 0, d_rvalid=1, d_err=1, d_rdata=0, and memory is unchanged.
REQ-030 reset_n driven low mid-ACCESS of a store -> mem_we falls without a clock edge, no rvalid follows, and after release the state is IDLE with all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single-ported memory.
// Each access runs IDLE/RESP -> ACCESS -> RESP, so a new grant can overlap the
// previous response and one access completes every two cycles.
module mem_port_arbiter #(
    parameter int unsigned FIRST_PRIO = 0  // 0: fetch wins first contest, 1: data
) (
    input  logic        clk,
    input  logic        reset_n,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // memory side
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_wm,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // last_q = 1 means the data port was granted last; reset so FIRST_PRIO wins.
    localparam logic LastRst = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;  // 1 = data port owns the access in flight
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;

    logic        accept;
    logic        acc_err;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Grants are combinational; reset_n is folded in so no grant shows during reset.
    always_comb begin
        accept = reset_n && (state_q == StIdle || state_q == StResp);
        i_gnt  = accept && i_req && (!d_req || last_q);
        d_gnt  = accept && d_req && (!i_req || !last_q);
    end

    // Alignment / legal-size check on the latched access (fetch is latched as word).
    always_comb begin
        acc_err = 1'b0;
        case (size_q)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = addr_q[0];
            2'b10:   acc_err = |addr_q[1:0];
            default: acc_err = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension of the memory read word.
    always_comb begin
        ld_byte   = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half   = mem_rd[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_rd;
        case (size_q)
            2'b00:   load_data = {{24{!uns_q && ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{!uns_q && ld_half[15]}}, ld_half};
            default: load_data = mem_rd;
        endcase
    end

    // Memory-side drive: store data is replicated across lanes, the mask picks the lanes.
    always_comb begin
        mem_a  = addr_q;
        mem_we = (state_q == StAccess) && we_q && !acc_err;
        mem_wm = 4'b0000;
        case (size_q)
            2'b00:   mem_wd = {4{wdata_q[7:0]}};
            2'b01:   mem_wd = {2{wdata_q[15:0]}};
            default: mem_wd = wdata_q;
        endcase
        if (mem_we) begin
            case (size_q)
                2'b00:   mem_wm = 4'b0001 << addr_q[1:0];
                2'b01:   mem_wm = addr_q[1] ? 4'b1100 : 4'b0011;
                default: mem_wm = 4'b1111;
            endcase
        end
    end

    // Response outputs are only live on the port that owns the access in RESP.
    always_comb begin
        i_rvalid = (state_q == StResp) && !port_q;
        d_rvalid = (state_q == StResp) && port_q;
        i_rdata  = i_rvalid ? rdata_q : 32'h0;
        d_rdata  = d_rvalid ? rdata_q : 32'h0;
        i_err    = i_rvalid && err_q;
        d_err    = d_rvalid && err_q;
    end

    // Next-state: latch the winner's request on grant, capture the result in ACCESS.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StResp: begin
                if (i_gnt || d_gnt) begin
                    state_d = StAccess;
                    last_d  = d_gnt;
                    port_d  = d_gnt;
                    if (d_gnt) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        size_d  = d_size;
                        we_d    = d_we;
                        uns_d   = d_unsigned;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = 32'h0;
                        size_d  = 2'b10;
                        we_d    = 1'b0;
                        uns_d   = 1'b0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                rdata_d = acc_err ? 32'h0 : load_data;
                err_d   = acc_err;
                state_d = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= LastRst;
            port_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random single accesses
// checked against a byte-addressed reference memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [3:0]  mem_wm;

    logic [7:0]  ram     [0:255];  // memory seen by the DUT
    logic [7:0]  ref_mem [0:255];  // expected memory contents
    logic        load_ram;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wm(mem_wm), .mem_rd(mem_rd)
    );

    assign mem_rd = {ram[{mem_a[7:2], 2'd3}], ram[{mem_a[7:2], 2'd2}],
                     ram[{mem_a[7:2], 2'd1}], ram[{mem_a[7:2], 2'd0}]};

    // Memory: bulk preload from the reference image, otherwise masked byte writes.
    always @(posedge clk) begin
        if (load_ram) begin
            for (int k = 0; k < 256; k++) ram[k] <= ref_mem[k];
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_wm[k]) ram[{mem_a[7:2], 2'(k)}] <= mem_wd[8*k +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ref_mem[a + k] = w[8*k +: 8];
    endtask

    // One access from the current negedge: request, grant, ACCESS and RESP checks.
    task automatic txn(input bit port, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd_obs);
        int          n, a, base, cyc;
        bit          err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_wm;
        a      = int'(addr);
        n      = port ? (1 << size) : 4;
        err    = (port && size == 2'd3) || (a % n != 0);
        exp_rd = 32'h0;
        exp_wm = 4'b0000;
        if (!err) begin
            for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_mem[a + k];
            if (port && !uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
            if (port && we) begin
                base = a & ~3;
                for (int k = 0; k < 4; k++)
                    if (base + k >= a && base + k < a + n) exp_wm[k] = 1'b1;
            end
        end
        if (port) begin
            d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
            d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1;
        cyc = 0;
        while (!(port ? d_gnt : i_gnt) && cyc < 8) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("gnt", port ? d_gnt : i_gnt, 1'b1);
        check("gnt_other", port ? i_gnt : d_gnt, 1'b0);
        @(negedge clk);
        // Drop the request and scramble the fields: the latched copy must be used.
        i_req = 1'b0; d_req = 1'b0;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom); d_size = 2'($urandom); d_unsigned = 1'($urandom);
        #1;
        check("access_mem_we", mem_we, exp_wm != 4'b0000);
        check("access_mem_wm", mem_wm, exp_wm);
        check("access_mem_a", mem_a, addr);
        check("access_no_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        @(negedge clk);
        #1;
        check("rvalid", port ? d_rvalid : i_rvalid, 1'b1);
        check("rvalid_other", port ? i_rvalid : d_rvalid, 1'b0);
        check("err", port ? d_err : i_err, err);
        if (err || !we) check("rdata", port ? d_rdata : i_rdata, exp_rd);
        rd_obs = port ? d_rdata : i_rdata;
        if (port && we && !err)
            for (int k = 0; k < n; k++) ref_mem[a + k] = wdata[8*k +: 8];
    endtask

    logic [31:0] rd, r_addr, r_wdata;
    logic [1:0]  r_size;
    bit          r_port, r_we, r_uns;
    int          sel, bad;

    initial begin
        reset_n = 1'b0; load_ram = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'($urandom);
        set_word(32'h10, 32'h00A0_0093);
        set_word(32'h20, 32'h8001_0000);
        load_ram = 1'b1;
        @(posedge clk);
        #1 load_ram = 1'b0;

        // Reset values.
        check("rst_gnt", {i_gnt, d_gnt}, 2'b00);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        check("rst_err", {i_err, d_err}, 2'b00);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wm", mem_wm, 4'b0000);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);

        // Both ports contend from reset: I, D, I, ... on every accept cycle.
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h20;
        #1 check("gnt_during_reset", {i_gnt, d_gnt}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("arb_i_gnt", i_gnt, c % 4 == 0);
            check("arb_d_gnt", d_gnt, c % 4 == 2);
            check("arb_no_double", i_gnt & d_gnt, 1'b0);
            check("arb_i_rvalid", i_rvalid, c == 2 || c == 6);
            check("arb_d_rvalid", d_rvalid, c == 4);
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Held fetch request: one grant every two cycles, grant overlapping rvalid.
        i_req = 1'b1; i_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("tput_gnt", i_gnt, c % 2 == 0);
            check("tput_rvalid", i_rvalid, c >= 2 && c % 2 == 0);
            if (c >= 2 && c % 2 == 0) check("tput_rdata", i_rdata, 32'h00A0_0093);
            @(negedge clk);
        end
        i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
        check("fetch_0x10", rd, 32'h00A0_0093);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd);
        check("lh_signed_0x22", rd, 32'hFFFF_8001);
        txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd);
        check("lhu_0x22", rd, 32'h0000_8001);
        txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_00AB, rd);
        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
        check("sb_0x23_lane3", rd[31:24], 8'hAB);
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h1234_5678, rd);
        check("sw_misaligned_rdata", rd, 32'h0);

        // Random single accesses.
        for (int t = 0; t < 80; t++) begin
            r_port = 1'($urandom);
            r_we   = 1'($urandom);
            r_uns  = 1'($urandom);
            sel    = int'($urandom_range(0, 9));
            r_size = (sel == 9) ? 2'b11 : 2'(sel % 3);
            r_addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            txn(r_port, r_we, r_size, r_uns, r_addr, r_wdata, rd);
        end

        // Reset asserted in the ACCESS cycle of a store.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_unsigned = 1'b0;
        d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        #1 check("rst_store_gnt", d_gnt, 1'b1);
        @(negedge clk);
        d_req = 1'b0;
        #1 check("rst_store_mem_we", mem_we, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_mem_we", mem_we, 1'b0);
        check("async_mem_wm", mem_wm, 4'b0000);
        check("async_mem_a", mem_a, 32'h0);
        check("async_mem_wd", mem_wd, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("post_rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
            check("post_rst_gnt", {i_gnt, d_gnt}, 2'b00);
            check("post_rst_mem_we", mem_we, 1'b0);
            @(negedge clk);
        end

        bad = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== ref_mem[k]) bad++;
        check("mem_image_bad_bytes", 32'(bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
